// File: rtl/multicycle_ctrl.sv
// Sequencing FSM for a multi-cycle RV32I datapath: fetch, execute, optional data
// access and write-back, with req/ack memory handshakes, retire counter and timeouts.
module multicycle_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_isLoad,
  input  logic        i_isStore,
  input  logic        i_regWriteReq,
  input  logic        i_halt,
  input  logic        i_resume,
  input  logic        i_imemAck,
  input  logic        i_dmemAck,
  output logic        o_imemReq,
  output logic        o_instLatchEn,
  output logic        o_dmemReq,
  output logic        o_dmemWe,
  output logic        o_PCEnable,
  output logic        o_regWrite,
  output logic        o_busy,
  output logic        o_halted,
  output logic        o_error,
  output logic [31:0] o_instret
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    EXEC  = 3'd2,
    MEM   = 3'd3,
    WB    = 3'd4,
    HALT  = 3'd5,
    ERR   = 3'd6
  } state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   wait_cnt_reg, wait_cnt_next;
  logic [31:0]        instret_reg;
  logic               timed_out;

  // Last permitted wait cycle; a zero TIMEOUT disables the check entirely.
  assign timed_out = (TIMEOUT != 0) && (wait_cnt_reg == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = '0;
    o_imemReq     = 1'b0;
    o_instLatchEn = 1'b0;
    o_dmemReq     = 1'b0;
    o_dmemWe      = 1'b0;
    o_PCEnable    = 1'b0;
    o_regWrite    = 1'b0;
    o_busy        = 1'b0;
    o_halted      = 1'b0;
    o_error       = 1'b0;

    case (state_reg)
      IDLE: begin
        state_next = FETCH;
      end
      FETCH: begin
        o_imemReq     = 1'b1;
        o_busy        = 1'b1;
        o_instLatchEn = i_imemAck;
        if (i_imemAck) begin
          state_next = EXEC;
        end else if (timed_out) begin
          state_next = ERR;
        end else begin
          wait_cnt_next = wait_cnt_reg + 1'b1;
        end
      end
      EXEC: begin
        o_busy = 1'b1;
        if (i_isLoad && i_isStore) begin
          state_next = ERR;
        end else if (i_isLoad || i_isStore) begin
          state_next = MEM;
        end else begin
          state_next = WB;
        end
      end
      MEM: begin
        o_dmemReq = 1'b1;
        o_dmemWe  = i_isStore;
        o_busy    = 1'b1;
        if (i_dmemAck) begin
          state_next = WB;
        end else if (timed_out) begin
          state_next = ERR;
        end else begin
          wait_cnt_next = wait_cnt_reg + 1'b1;
        end
      end
      WB: begin
        o_PCEnable = 1'b1;
        o_regWrite = i_regWriteReq;
        o_busy     = 1'b1;
        state_next = i_halt ? HALT : FETCH;
      end
      HALT: begin
        o_halted = 1'b1;
        if (i_resume) begin
          state_next = FETCH;
        end
      end
      ERR: begin
        o_error = 1'b1;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg    <= IDLE;
      wait_cnt_reg <= '0;
      instret_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      if (state_reg == WB) begin
        instret_reg <= instret_reg + 32'd1;
      end
    end
  end

  assign o_instret = instret_reg;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: a directed cycle table, hand-written corner
// sequences, and randomized instruction streams checked against a transaction model.
module tb_multicycle_ctrl;

  localparam int TO = 4;

  // Output vector order: imemReq, instLatchEn, dmemReq, dmemWe, PCEnable, regWrite,
  // busy, halted, error.
  localparam logic [8:0] IDLE_O      = 9'b0_0_0_0_0_0_0_0_0;
  localparam logic [8:0] FETCH_NOACK = 9'b1_0_0_0_0_0_1_0_0;
  localparam logic [8:0] FETCH_ACK   = 9'b1_1_0_0_0_0_1_0_0;
  localparam logic [8:0] EXEC_O      = 9'b0_0_0_0_0_0_1_0_0;
  localparam logic [8:0] MEM_LD      = 9'b0_0_1_0_0_0_1_0_0;
  localparam logic [8:0] MEM_ST      = 9'b0_0_1_1_0_0_1_0_0;
  localparam logic [8:0] WB_RW       = 9'b0_0_0_0_1_1_1_0_0;
  localparam logic [8:0] WB_NORW     = 9'b0_0_0_0_1_0_1_0_0;
  localparam logic [8:0] HALT_O      = 9'b0_0_0_0_0_0_0_1_0;
  localparam logic [8:0] ERR_O       = 9'b0_0_0_0_0_0_0_0_1;

  logic        clk = 1'b0;
  logic        i_reset, i_isLoad, i_isStore, i_regWriteReq, i_halt, i_resume;
  logic        i_imemAck, i_dmemAck;
  logic        o_imemReq, o_instLatchEn, o_dmemReq, o_dmemWe, o_PCEnable, o_regWrite;
  logic        o_busy, o_halted, o_error;
  logic [31:0] o_instret;
  logic [8:0]  outs;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [31:0] exp_instret = '0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.TIMEOUT(TO), .CNT_W(3)) dut (
    .i_clk         (clk),
    .i_reset       (i_reset),
    .i_isLoad      (i_isLoad),
    .i_isStore     (i_isStore),
    .i_regWriteReq (i_regWriteReq),
    .i_halt        (i_halt),
    .i_resume      (i_resume),
    .i_imemAck     (i_imemAck),
    .i_dmemAck     (i_dmemAck),
    .o_imemReq     (o_imemReq),
    .o_instLatchEn (o_instLatchEn),
    .o_dmemReq     (o_dmemReq),
    .o_dmemWe      (o_dmemWe),
    .o_PCEnable    (o_PCEnable),
    .o_regWrite    (o_regWrite),
    .o_busy        (o_busy),
    .o_halted      (o_halted),
    .o_error       (o_error),
    .o_instret     (o_instret)
  );

  assign outs = {o_imemReq, o_instLatchEn, o_dmemReq, o_dmemWe, o_PCEnable, o_regWrite,
                 o_busy, o_halted, o_error};

  typedef struct {
    logic        ld, st, rw, halt, resume, iack, dack;
    logic [8:0]  exp;
    logic [31:0] inst;
  } vec_t;

  vec_t tbl[22];

  function automatic vec_t mk(input logic ld, input logic st, input logic rw,
                              input logic halt, input logic resume, input logic iack,
                              input logic dack, input logic [8:0] exp, input logic [31:0] inst);
    vec_t r;
    r.ld = ld; r.st = st; r.rw = rw; r.halt = halt; r.resume = resume;
    r.iack = iack; r.dack = dack; r.exp = exp; r.inst = inst;
    return r;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Inputs are already driven; check at the falling edge, then advance past the rising edge.
  task automatic step(input logic [8:0] e, input logic [31:0] ei, input string nm);
    @(negedge clk);
    total++;
    if (outs !== e) begin
      bad++;
      $display("FAIL %s cycle=%0d outputs=%b required=%b", nm, cyc, outs, e);
    end
    total++;
    if (o_instret !== ei) begin
      bad++;
      $display("FAIL %s_instret cycle=%0d instret=%0d required=%0d", nm, cyc, o_instret, ei);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_inputs();
    i_isLoad = 0; i_isStore = 0; i_regWriteReq = 0; i_halt = 0; i_resume = 0;
    i_imemAck = 0; i_dmemAck = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    i_reset = 1'b1;
    @(posedge clk);
    #1;
    step(IDLE_O, 32'd0, "reset_hold");
    i_reset = 1'b0;
    exp_instret = '0;
    step(IDLE_O, 32'd0, "reset_idle");
    $display("reset done cycle=%0d", cyc);
  endtask

  // One instruction from its first fetch cycle: kind 0=ALU 1=load 2=store, wi/wd = wait
  // states before ack, hc = cycles spent halted after it (0 = no halt). Acks on the idle
  // memory and other don't-care inputs are randomized to show they are ignored.
  task automatic run_instr(input int kind, input int wi, input int wd, input logic rw,
                           input int hc, input string nm);
    logic ld, st;
    ld = (kind == 1);
    st = (kind == 2);
    for (int k = 0; k <= wi; k++) begin
      i_imemAck = (k == wi); i_dmemAck = rb(); i_isLoad = rb(); i_isStore = rb();
      i_regWriteReq = rb(); i_halt = rb(); i_resume = rb();
      step((k == wi) ? FETCH_ACK : FETCH_NOACK, exp_instret, {nm, "/fetch"});
    end
    i_isLoad = ld; i_isStore = st; i_regWriteReq = rw;
    i_imemAck = rb(); i_dmemAck = rb(); i_halt = rb(); i_resume = rb();
    step(EXEC_O, exp_instret, {nm, "/exec"});
    if (ld || st) begin
      for (int k = 0; k <= wd; k++) begin
        i_dmemAck = (k == wd); i_imemAck = rb(); i_halt = rb(); i_resume = rb();
        step(st ? MEM_ST : MEM_LD, exp_instret, {nm, "/mem"});
      end
    end
    i_halt = (hc > 0); i_imemAck = rb(); i_dmemAck = rb(); i_resume = rb();
    step(rw ? WB_RW : WB_NORW, exp_instret, {nm, "/wb"});
    exp_instret = exp_instret + 32'd1;
    if (hc > 0) begin
      for (int k = 0; k < hc; k++) begin
        i_resume = 1'b0; i_imemAck = rb(); i_dmemAck = rb(); i_halt = rb();
        step(HALT_O, exp_instret, {nm, "/halted"});
      end
      i_resume = 1'b1;
      step(HALT_O, exp_instret, {nm, "/resume"});
    end
    clear_inputs();
    $display("instr %s kind=%0d imem_wait=%0d dmem_wait=%0d rw=%0d halt_cycles=%0d instret=%0d",
             nm, kind, wi, wd, rw, hc, o_instret);
  endtask

  initial begin
    // Directed cycle table starting in the first FETCH after reset.
    tbl[0]  = mk(0, 0, 0, 0, 0, 1, 0, FETCH_ACK,   32'd0);  // ADD
    tbl[1]  = mk(0, 0, 1, 0, 0, 0, 1, EXEC_O,      32'd0);
    tbl[2]  = mk(0, 0, 1, 0, 0, 0, 0, WB_RW,       32'd0);
    tbl[3]  = mk(0, 0, 0, 0, 0, 1, 0, FETCH_ACK,   32'd1);  // LW, 2 dmem wait states
    tbl[4]  = mk(1, 0, 1, 0, 0, 0, 0, EXEC_O,      32'd1);
    tbl[5]  = mk(1, 0, 1, 0, 0, 1, 0, MEM_LD,      32'd1);
    tbl[6]  = mk(1, 0, 1, 0, 0, 0, 0, MEM_LD,      32'd1);
    tbl[7]  = mk(1, 0, 1, 0, 0, 0, 1, MEM_LD,      32'd1);
    tbl[8]  = mk(1, 0, 1, 0, 0, 0, 0, WB_RW,       32'd1);
    tbl[9]  = mk(0, 0, 0, 0, 0, 1, 0, FETCH_ACK,   32'd2);  // SW, no rd write
    tbl[10] = mk(0, 1, 0, 0, 0, 0, 0, EXEC_O,      32'd2);
    tbl[11] = mk(0, 1, 0, 0, 0, 0, 1, MEM_ST,      32'd2);
    tbl[12] = mk(0, 1, 0, 0, 0, 0, 0, WB_NORW,     32'd2);
    tbl[13] = mk(0, 0, 0, 0, 0, 0, 1, FETCH_NOACK, 32'd3);  // ECALL after 1 imem wait
    tbl[14] = mk(0, 0, 0, 0, 0, 1, 0, FETCH_ACK,   32'd3);
    tbl[15] = mk(0, 0, 1, 0, 0, 0, 0, EXEC_O,      32'd3);
    tbl[16] = mk(0, 0, 1, 1, 0, 0, 0, WB_RW,       32'd3);
    tbl[17] = mk(0, 0, 0, 0, 0, 1, 1, HALT_O,      32'd4);
    tbl[18] = mk(0, 0, 0, 0, 1, 0, 0, HALT_O,      32'd4);
    tbl[19] = mk(0, 0, 0, 0, 0, 1, 0, FETCH_ACK,   32'd4);
    tbl[20] = mk(0, 0, 0, 0, 0, 0, 0, EXEC_O,      32'd4);
    tbl[21] = mk(0, 0, 0, 0, 0, 0, 0, WB_NORW,     32'd4);

    do_reset();
    for (int i = 0; i < 22; i++) begin
      i_isLoad = tbl[i].ld; i_isStore = tbl[i].st; i_regWriteReq = tbl[i].rw;
      i_halt = tbl[i].halt; i_resume = tbl[i].resume;
      i_imemAck = tbl[i].iack; i_dmemAck = tbl[i].dack;
      step(tbl[i].exp, tbl[i].inst, $sformatf("table%0d", i));
    end
    clear_inputs();
    exp_instret = 32'd5;
    $display("table done instret=%0d", o_instret);

    // Ack on the last permitted wait cycle, then a 10-cycle halt.
    run_instr(0, TO - 1, 0, 1'b1, 10, "imem_boundary_halt");
    run_instr(1, 0, TO - 1, 1'b1, 0, "dmem_boundary");

    // Instruction memory never acks: req high for exactly TO cycles, then sticky ERR.
    do_reset();
    for (int k = 0; k < TO; k++) step(FETCH_NOACK, 32'd0, "imem_timeout");
    i_imemAck = 1; i_dmemAck = 1; i_resume = 1;
    for (int k = 0; k < 3; k++) step(ERR_O, 32'd0, "err_sticky");
    $display("imem timeout error=%0d", o_error);

    // Data memory never acks on a store.
    do_reset();
    i_imemAck = 1; step(FETCH_ACK, 32'd0, "dto_fetch");
    clear_inputs(); i_isStore = 1; step(EXEC_O, 32'd0, "dto_exec");
    for (int k = 0; k < TO; k++) step(MEM_ST, 32'd0, "dmem_timeout");
    clear_inputs(); i_dmemAck = 1;
    step(ERR_O, 32'd0, "dmem_err");
    $display("dmem timeout error=%0d", o_error);

    // Load and store decoded together is illegal.
    do_reset();
    i_imemAck = 1; step(FETCH_ACK, 32'd0, "illegal_fetch");
    clear_inputs(); i_isLoad = 1; i_isStore = 1; step(EXEC_O, 32'd0, "illegal_exec");
    clear_inputs(); step(ERR_O, 32'd0, "illegal_err");
    $display("illegal ld+st error=%0d", o_error);

    // Reset while a data request is outstanding.
    do_reset();
    run_instr(0, 0, 0, 1'b1, 0, "pre_reset");
    i_imemAck = 1; step(FETCH_ACK, exp_instret, "rst_fetch");
    clear_inputs(); i_isLoad = 1; step(EXEC_O, exp_instret, "rst_exec");
    step(MEM_LD, exp_instret, "rst_mem");
    i_reset = 1; step(MEM_LD, exp_instret, "rst_assert");
    i_reset = 0; clear_inputs(); exp_instret = '0;
    step(IDLE_O, 32'd0, "rst_idle");
    step(FETCH_NOACK, 32'd0, "rst_fetch_again");
    $display("mid-MEM reset instret=%0d", o_instret);

    // Retire counter wraps from all-ones to zero.
    do_reset();
    force dut.instret_reg = 32'hFFFF_FFFF;
    #1;
    release dut.instret_reg;
    exp_instret = 32'hFFFF_FFFF;
    run_instr(0, 0, 0, 1'b0, 0, "wrap");
    run_instr(2, 1, 1, 1'b0, 0, "post_wrap");

    // Randomized instruction stream.
    do_reset();
    for (int n = 0; n < 60; n++) begin
      int kind, wi, wd, hc;
      logic rw;
      kind = $urandom_range(0, 2);
      wi   = $urandom_range(0, TO - 1);
      wd   = $urandom_range(0, TO - 1);
      rw   = rb();
      hc   = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 4) : 0;
      run_instr(kind, wi, wd, rw, hc, $sformatf("rand%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
